rx_unstuff_deser: RTL and testbench
===================================

Name: rx_unstuff_deser

Overview:
- Sits directly downstream of the receiver NRZI decoder.
- Consumes the decoded bit stream, hunts for SYNC, removes stuffed bits and assembles LSB-first bytes for the receive controller.
- Also reports packet framing: SYNC found, clean EOP, stuff/alignment/decode errors, and a per-packet byte count.

Parameters:
- SYNC_PATTERN, 8'h80, shift-register value after the decoded SYNC (0,0,0,0,0,0,0,1 LSB-first, new bit enters at MSB).
- STUFF_LEN, 6, consecutive 1s after which a stuffed 0 is mandatory.
- CNT_W, 7, width of byte_count.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- restart  in  1  synchronous clear to IDLE, same cycle as decoder restart
- bit_valid  in  1  one-cycle strobe; bit_in valid this cycle. Top level forms it as decoder sample_en registered by one cycle.
- bit_in  in  1  decoder d_orig
- eop_in  in  1  decoder end_packet registered by one cycle, aligned with bit_valid
- dec_err_in  in  1  decoder error registered by one cycle
- rcv_byte  out  8  last assembled byte
- byte_ready  out  1  one-cycle pulse, rcv_byte updated same cycle
- sync_found  out  1  one-cycle pulse
- eop_ok  out  1  one-cycle pulse on clean packet end
- rx_error  out  1  sticky error flag
- packet_active  out  1  high in DATA
- byte_count  out  CNT_W  bytes delivered this packet, saturating

Behaviour:
- Reset and restart values (all outputs and state):
  - state IDLE; shift reg 0; rcv_byte 0; all pulses 0; rx_error 0; byte_count 0; ones_cnt 0; bit_cnt 0.
  - restart takes priority over every other input.
- IDLE:
  - On bit_valid, shift bit_in in at MSB (shift right).
  - When the post-shift value equals SYNC_PATTERN: pulse sync_found the same cycle; go DATA; bit_cnt=0; ones_cnt=1; byte_count=0; clear rx_error.
  - eop_in and dec_err_in are ignored in IDLE.
- DATA, processed on bit_valid:
  - If ones_cnt==STUFF_LEN and bit_in==0: discard the bit; ones_cnt=0; bit_cnt unchanged.
  - If ones_cnt==STUFF_LEN and bit_in==1: set rx_error; go ERROR.
  - Otherwise: shift in the bit; ones_cnt = bit_in ? ones_cnt+1 : 0; bit_cnt++.
  - When bit_cnt reaches 8: next-cycle rcv_byte = shifted value; pulse byte_ready; bit_cnt=0; byte_count++, saturating at all-ones.
  - Latency: byte_ready rises on the clock edge after the bit_valid carrying the 8th data bit.
- EOP in DATA:
  - eop_in with bit_cnt==0: pulse eop_ok; go IDLE.
  - eop_in with bit_cnt!=0: set rx_error (alignment); go IDLE; no eop_ok.
- Decode error in DATA: dec_err_in sets rx_error and moves to ERROR.
- ERROR:
  - Ignore bits.
  - eop_in returns to IDLE; no eop_ok.
  - packet_active low.
- Priority in DATA: dec_err_in > eop_in > bit_valid.
  - A bit arriving with eop_in is dropped.
  - A bit arriving with dec_err_in is dropped.
- Pulse/level rules:
  - rx_error holds until the next sync_found, restart or reset.
  - byte_count holds after the packet until the next sync_found.
  - byte_ready and eop_ok are never high in the same cycle.
- No bit_valid: state and counters hold.

Decomposition:
- Shared package rx_pkg: state enum (IDLE, DATA, ERROR), SYNC_PATTERN default, STUFF_LEN default.
- Natural sub-module: rx_shift_reg. 8-bit right shift register with shift enable and sync clear, reused by the byte assembler. Everything else lives in one FSM module.

Test Plan:
- SYNC 0,0,0,0,0,0,0,1, then data bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), then EOP → sync_found, byte_ready with rcv_byte=8'hA5, byte_count=1, eop_ok, rx_error=0.
- After SYNC, send 0xFF with a stuffed 0 after the 5th data bit (the SYNC 1 counts toward six) → rcv_byte=8'hFF; the stuffed 0 is not counted; byte_ready occurs exactly once.
- After SYNC, send seven consecutive 1s → rx_error=1 and state ERROR. Subsequent bits produce no byte_ready. EOP returns to IDLE; the next SYNC clears rx_error.
- After SYNC, send 3 data bits then EOP → rx_error=1, no eop_ok, packet_active=0.
- Assert dec_err_in mid-byte → rx_error=1 with no byte_ready. Assert restart mid-packet → all outputs return to reset values next cycle.
- Send 130 bytes in one packet with CNT_W=7 → byte_count saturates at 127. Assert eop_in and bit_valid together on a byte boundary → eop_ok, and the bit is dropped.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and defaults for the receive unstuffer / deserializer.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_ERROR = 2'd2
  } rx_state_e;

  // Shift-register value after the last SYNC bit (0000_0001 LSB-first).
  localparam logic [7:0] SYNC_PATTERN_DEF = 8'h80;
  localparam int         STUFF_LEN_DEF    = 6;
  localparam int         CNT_W_DEF        = 7;

endpackage

// File: rtl/rx_shift_reg.sv
// 8-bit right shift register: new bit enters at the MSB, so LSB-first
// serial data is byte-aligned after eight shifts.
module rx_shift_reg (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr_i,
  input  logic       shift_en_i,
  input  logic       bit_i,
  output logic [7:0] q_o,
  output logic [7:0] next_o
);

  logic [7:0] sr_q;

  assign next_o = {bit_i, sr_q[7:1]};
  assign q_o    = sr_q;

  // Shift register with synchronous clear taking priority over shifting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= 8'h00;
    end else if (clr_i) begin
      sr_q <= 8'h00;
    end else if (shift_en_i) begin
      sr_q <= next_o;
    end else begin
      sr_q <= sr_q;
    end
  end

endmodule

// File: rtl/rx_unstuff_deser.sv
// SYNC hunt, bit unstuffing and LSB-first byte assembly for the receive path,
// with packet framing pulses, sticky error flag and saturating byte count.
module rx_unstuff_deser
  import rx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int         STUFF_LEN    = STUFF_LEN_DEF,
  parameter int         CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             restart,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             eop_in,
  input  logic             dec_err_in,
  output logic [7:0]       rcv_byte,
  output logic             byte_ready,
  output logic             sync_found,
  output logic             eop_ok,
  output logic             rx_error,
  output logic             packet_active,
  output logic [CNT_W-1:0] byte_count
);

  localparam int              OW        = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0]   ONES_MAX  = OW'(STUFF_LEN);
  localparam logic [OW-1:0]   ONES_ONE  = OW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [7:0]       rcv_byte_q, rcv_byte_d;
  logic             byte_ready_q, byte_ready_d;
  logic             sync_found_q, sync_found_d;
  logic             eop_ok_q, eop_ok_d;
  logic             rx_error_q, rx_error_d;
  logic             active_q, active_d;
  logic             shift_en_s;
  logic [7:0]       sr_q_s, sr_next_s;

  rx_shift_reg u_shift (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (restart),
    .shift_en_i (shift_en_s),
    .bit_i      (bit_in),
    .q_o        (sr_q_s),
    .next_o     (sr_next_s)
  );

  // Next-state and output decode; in DATA: decode error > EOP > bit.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    byte_count_d = byte_count_q;
    rcv_byte_d   = rcv_byte_q;
    rx_error_d   = rx_error_q;
    byte_ready_d = 1'b0;
    sync_found_d = 1'b0;
    eop_ok_d     = 1'b0;
    shift_en_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bit_valid) begin
          shift_en_s = 1'b1;
          if (sr_next_s == SYNC_PATTERN) begin
            sync_found_d = 1'b1;
            state_d      = ST_DATA;
            bit_cnt_d    = 3'd0;
            ones_d       = ONES_ONE;
            byte_count_d = {CNT_W{1'b0}};
            rx_error_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (dec_err_in) begin
          rx_error_d = 1'b1;
          state_d    = ST_ERROR;
        end else if (eop_in) begin
          state_d = ST_IDLE;
          if (bit_cnt_q == 3'd0) begin
            eop_ok_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
        end else if (bit_valid) begin
          if (ones_q == ONES_MAX) begin
            // After a full run of ones the next bit must be a stuffed zero.
            if (!bit_in) begin
              ones_d = {OW{1'b0}};
            end else begin
              rx_error_d = 1'b1;
              state_d    = ST_ERROR;
            end
          end else begin
            shift_en_s = 1'b1;
            ones_d     = bit_in ? (ones_q + ONES_ONE) : {OW{1'b0}};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d    = 3'd0;
              rcv_byte_d   = sr_next_s;
              byte_ready_d = 1'b1;
              byte_count_d = (byte_count_q == CNT_FULL) ? byte_count_q
                                                         : (byte_count_q + CNT_ONE);
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_ERROR: begin
        if (eop_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d == ST_DATA);
  end

  // State and registered outputs; restart clears everything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      ones_q       <= {OW{1'b0}};
      byte_count_q <= {CNT_W{1'b0}};
      rcv_byte_q   <= 8'h00;
      rx_error_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      sync_found_q <= 1'b0;
      eop_ok_q     <= 1'b0;
      active_q     <= 1'b0;
    end else if (restart) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      ones_q       <= {OW{1'b0}};
      byte_count_q <= {CNT_W{1'b0}};
      rcv_byte_q   <= 8'h00;
      rx_error_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      sync_found_q <= 1'b0;
      eop_ok_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      byte_count_q <= byte_count_d;
      rcv_byte_q   <= rcv_byte_d;
      rx_error_q   <= rx_error_d;
      byte_ready_q <= byte_ready_d;
      sync_found_q <= sync_found_d;
      eop_ok_q     <= eop_ok_d;
      active_q     <= active_d;
    end
  end

  assign rcv_byte      = rcv_byte_q;
  assign byte_ready    = byte_ready_q;
  assign sync_found    = sync_found_q;
  assign eop_ok        = eop_ok_q;
  assign rx_error      = rx_error_q;
  assign packet_active = active_q;
  assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_rx_unstuff_deser.sv
// Scoreboard bench for rx_unstuff_deser: directed packets push expected
// pulses into a queue, a monitor pops and compares them as they appear.
module tb_rx_unstuff_deser;

  localparam int CNT_W = 7;
  localparam int EV_SYNC = 0;
  localparam int EV_BYTE = 1;
  localparam int EV_EOP  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             restart = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             eop_in = 1'b0;
  logic             dec_err_in = 1'b0;
  logic [7:0]       rcv_byte;
  logic             byte_ready;
  logic             sync_found;
  logic             eop_ok;
  logic             rx_error;
  logic             packet_active;
  logic [CNT_W-1:0] byte_count;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  tx_ones = 0;
  int  exp_cnt = 0;

  rx_unstuff_deser #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .restart       (restart),
    .bit_valid     (bit_valid),
    .bit_in        (bit_in),
    .eop_in        (eop_in),
    .dec_err_in    (dec_err_in),
    .rcv_byte      (rcv_byte),
    .byte_ready    (byte_ready),
    .sync_found    (sync_found),
    .eop_ok        (eop_ok),
    .rx_error      (rx_error),
    .packet_active (packet_active),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input int cnt);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // One strobed bit, followed by an idle cycle.
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Transmitter-side stuffing: a 0 is inserted after six consecutive 1s.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    push(EV_SYNC, 8'h00, 0);
    exp_cnt = 0;
    send_bit(1'b1);
    tx_ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_cnt = (exp_cnt < 127) ? exp_cnt + 1 : 127;
    push(EV_BYTE, d, exp_cnt);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic send_eop(input logic ok, input logic with_bit);
    @(negedge clk);
    eop_in    = 1'b1;
    bit_valid = with_bit;
    bit_in    = with_bit;
    if (ok) push(EV_EOP, 8'h00, 0);
    @(negedge clk);
    eop_in    = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (byte_ready && eop_ok) chk("byte_ready_eop_ok_overlap", 1, 0);
        if (sync_found) begin
          if (exp_q.size() == 0) chk("unexpected_sync", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sync_kind", EV_SYNC, e.kind);
            chk("sync_byte_count", 32'(byte_count), 0);
            chk("sync_rx_error", 32'(rx_error), 0);
          end
        end
        if (byte_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("byte_kind", EV_BYTE, e.kind);
            chk("rcv_byte", 32'(rcv_byte), 32'(e.data));
            chk("byte_count", 32'(byte_count), e.cnt);
          end
        end
        if (eop_ok) begin
          if (exp_q.size() == 0) chk("unexpected_eop_ok", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("eop_kind", EV_EOP, e.kind);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rcv_byte", 32'(rcv_byte), 0);
    chk("reset_byte_count", 32'(byte_count), 0);
    chk("reset_pulses", 32'({byte_ready, sync_found, eop_ok}), 0);
    chk("reset_rx_error", 32'(rx_error), 0);
    chk("reset_active", 32'(packet_active), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic packet: SYNC, 0xA5, clean EOP.
    send_sync();
    chk("a5_active_after_sync", 32'(packet_active), 1);
    send_byte(8'hA5);
    send_eop(1'b1, 1'b0);
    drain("a5_pending");
    chk("a5_rx_error", 32'(rx_error), 0);
    chk("a5_active_after_eop", 32'(packet_active), 0);
    chk("a5_byte_count_hold", 32'(byte_count), 1);

    // 0xFF with a stuffed zero after the fifth data bit.
    send_sync();
    send_byte(8'hFF);
    send_eop(1'b1, 1'b0);
    drain("ff_pending");
    chk("ff_rx_error", 32'(rx_error), 0);
    chk("ff_byte_count", 32'(byte_count), 1);

    // Stuffing violation: seven raw 1s after SYNC.
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("stuff_err_rx_error", 32'(rx_error), 1);
    chk("stuff_err_active", 32'(packet_active), 0);
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    send_eop(1'b0, 1'b0);
    drain("stuff_err_pending");
    chk("stuff_err_sticky", 32'(rx_error), 1);
    send_sync();
    chk("sync_clears_rx_error", 32'(rx_error), 0);
    send_eop(1'b1, 1'b0);
    drain("empty_pkt_pending");

    // Misaligned EOP after three data bits.
    send_sync();
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_eop(1'b0, 1'b0);
    drain("align_pending");
    chk("align_rx_error", 32'(rx_error), 1);
    chk("align_active", 32'(packet_active), 0);

    // Decode error mid-byte.
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(1'b0);
    @(negedge clk);
    dec_err_in = 1'b1;
    bit_valid  = 1'b1;
    @(negedge clk);
    dec_err_in = 1'b0;
    bit_valid  = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    drain("dec_err_pending");
    chk("dec_err_rx_error", 32'(rx_error), 1);
    chk("dec_err_active", 32'(packet_active), 0);
    pulse_restart();
    chk("restart_in_error_rx_error", 32'(rx_error), 0);

    // Restart mid-packet after one delivered byte.
    send_sync();
    send_byte(8'h3C);
    for (int i = 0; i < 3; i++) send_data_bit(1'b1);
    drain("pre_restart_pending");
    pulse_restart();
    chk("restart_rcv_byte", 32'(rcv_byte), 0);
    chk("restart_byte_count", 32'(byte_count), 0);
    chk("restart_active", 32'(packet_active), 0);
    chk("restart_rx_error", 32'(rx_error), 0);

    // Long packet: byte_count saturates; EOP with a bit on a boundary.
    send_sync();
    for (int i = 0; i < 130; i++) send_byte(8'((i * 37 + 5) & 255));
    send_eop(1'b1, 1'b1);
    drain("sat_pending");
    chk("sat_byte_count", 32'(byte_count), 127);
    chk("sat_rx_error", 32'(rx_error), 0);
    chk("sat_active", 32'(packet_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
